// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core: NR rounds over a registered state, round keys
// expanded on the fly, UNROLL rounds per clock, valid/ready on both sides.
module aes128_iter_core #(
  parameter int NR     = 10,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Producers hold valid and data stable until the transfer; ready may change at any time.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_t;

  if (NR < 1 || NR > 10 || !(UNROLL == 1 || UNROLL == 2) || (NR % UNROLL) != 0) begin : g_bad_param
    $error("aes128_iter_core: illegal NR/UNROLL combination");
  end

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bits [2047-8b -: 8], i.e. top bit index {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the 128-bit word is state[row = i%4][col = i/4].
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   m [16];
    logic [7:0]   x0, x1, x2, x3, t;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      x0 = m[4*c];
      x1 = m[4*c+1];
      x2 = m[4*c+2];
      x3 = m[4*c+3];
      t  = x0 ^ x1 ^ x2 ^ x3;
      if (!last) begin
        m[4*c]   = x0 ^ t ^ xtime(x0 ^ x1);
        m[4*c+1] = x1 ^ t ^ xtime(x1 ^ x2);
        m[4*c+2] = x2 ^ t ^ xtime(x2 ^ x3);
        m[4*c+3] = x3 ^ t ^ xtime(x3 ^ x0);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i] ^ rk[127-8*i -: 8];
    return o;
  endfunction

  state_t        state, state_nx;
  logic [127:0]  st, rk, st_nx, rk_nx;
  logic [3:0]    rnd;
  logic          in_hs, out_hs, last_chunk;

  assign in_ready   = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign in_hs      = in_valid & in_ready;
  assign out_hs     = out_valid & out_ready;
  assign busy       = (state == S_ROUND);
  assign dbg_state  = state;
  assign last_chunk = (rnd + 4'(UNROLL - 1)) == 4'(NR);

  always_comb begin
    st_nx = st;
    rk_nx = rk;
    for (int u = 0; u < UNROLL; u++) begin
      rk_nx = key_expand(rk_nx, rcon(rnd + 4'(u)));
      st_nx = aes_round(st_nx, rk_nx, (rnd + 4'(u)) == 4'(NR));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_hs) state_nx = S_ROUND;
      S_ROUND: if (last_chunk) state_nx = S_DONE;
      S_DONE:  if (out_hs) state_nx = in_hs ? S_ROUND : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= '0;
      rk         <= '0;
      rnd        <= '0;
      ciphertext <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        S_ROUND: begin
          st  <= st_nx;
          rk  <= rk_nx;
          rnd <= rnd + 4'(UNROLL);
          if (last_chunk) begin
            ciphertext <= st_nx;
            out_valid  <= 1'b1;
          end
        end
        S_DONE:  if (out_hs) out_valid <= 1'b0;
        default: ;
      endcase
      // A load in DONE overlaps the output transfer, so there is no idle bubble.
      if (in_hs) begin
        st  <= plaintext ^ key;
        rk  <= key;
        rnd <= 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: FIPS-197 vectors, latency, backpressure,
// back-to-back transfer, mid-operation reset and the two-rounds-per-clock variant.
module tb_aes128_iter_core;

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk, rst_n, out_ready, in_valid1, in_valid2, sel;
  logic [127:0] pt, key;
  logic         in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2;
  logic [127:0] ct1, ct2;
  logic [1:0]   dbg1, dbg2;
  logic         m_in_ready, m_out_valid, m_busy;
  logic [127:0] m_ct;

  logic [127:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  aes128_iter_core #(.NR(10), .UNROLL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .plaintext(pt), .key(key), .out_valid(out_valid1), .out_ready(out_ready),
    .ciphertext(ct1), .busy(busy1), .dbg_state(dbg1)
  );

  aes128_iter_core #(.NR(10), .UNROLL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .plaintext(pt), .key(key), .out_valid(out_valid2), .out_ready(out_ready),
    .ciphertext(ct2), .busy(busy2), .dbg_state(dbg2)
  );

  always_comb begin
    m_in_ready  = sel ? in_ready2  : in_ready1;
    m_out_valid = sel ? out_valid2 : out_valid1;
    m_busy      = sel ? busy2      : busy1;
    m_ct        = sel ? ct2        : ct1;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in_valid(input logic v);
    if (sel) in_valid2 = v;
    else     in_valid1 = v;
  endtask

  // Present a block, expect it to be taken on the next edge; leaves us just past that edge.
  task automatic start(input string tag, input logic [127:0] p, input logic [127:0] k,
                       input logic [127:0] exp_ct);
    pt  = p;
    key = k;
    set_in_valid(1'b1);
    check({tag, "_in_ready"}, 128'(m_in_ready), 128'd1);
    tick();
    set_in_valid(1'b0);
    exp_q.push_back(exp_ct);
  endtask

  // Count edges since the input handshake until out_valid, then score the ciphertext.
  task automatic wait_out(input string tag, input int exp_lat, input int lat0);
    int lat;
    logic [127:0] exp_ct;
    lat = lat0;
    while (!m_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_ct"}, m_ct, exp_ct);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    sel = 1'b0; pt = '0; key = '0;

    #3;
    check("rst_out_valid", 128'(out_valid1), 128'd0);
    check("rst_busy",      128'(busy1),      128'd0);
    check("rst_ct",        ct1,              128'd0);
    check("rst_in_ready",  128'(in_ready1),  128'd0);
    check("rst_in_ready2", 128'(in_ready2),  128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 128'(in_ready1), 128'd1);
    check("idle_busy",     128'(busy1),     128'd0);

    // App.B vector, round-1 key check, latency 10
    out_ready = 1'b1;
    start("t1", PT1, K1, CT1);
    tick();
    check("t1_busy", 128'(busy1), 128'd1);
    check("t1_rk1",  u_dut1.rk,   RK1);
    wait_out("t1", 10, 1);
    tick();
    check("t1_out_valid_low", 128'(out_valid1), 128'd0);
    check("t1_ct_retained",   ct1,              CT1);
    check("t1_back_idle",     128'(in_ready1),  128'd1);

    // App.C.1 vector
    start("t2", PT2, K2, CT2);
    wait_out("t2", 10, 0);
    tick();
    check("t2_out_valid_low", 128'(out_valid1), 128'd0);

    // Backpressure for 5 clocks
    out_ready = 1'b0;
    start("t3", PT1, K1, CT1);
    wait_out("t3", 10, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 128'(out_valid1), 128'd1);
      check("t3_hold_ct",    ct1,              CT1);
      check("t3_hold_rdy",   128'(in_ready1),  128'd0);
    end
    out_ready = 1'b1;
    tick();
    check("t3_released", 128'(out_valid1), 128'd0);
    check("t3_idle",     128'(busy1),      128'd0);

    // Back-to-back: next block waits on in_valid through ROUND and DONE
    start("t4a", PT1, K1, CT1);
    pt = PT2;
    key = K2;
    in_valid1 = 1'b1;
    wait_out("t4a", 10, 0);
    check("t4_in_ready_done", 128'(in_ready1), 128'd1);
    exp_q.push_back(CT2);
    tick();
    in_valid1 = 1'b0;
    check("t4_no_bubble_valid", 128'(out_valid1), 128'd0);
    check("t4_no_bubble_busy",  128'(busy1),      128'd1);
    wait_out("t4b", 10, 0);
    tick();

    // Reset during ROUND
    start("t5", PT1, K1, CT1);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_valid", 128'(out_valid1), 128'd0);
    check("t5_rst_busy",  128'(busy1),      128'd0);
    check("t5_rst_ct",    ct1,              128'd0);
    check("t5_rst_rdy",   128'(in_ready1),  128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start("t5r", PT1, K1, CT1);
    wait_out("t5r", 10, 0);
    tick();

    // Two rounds per clock; a stray in_valid pulse during ROUND is ignored
    sel = 1'b1;
    start("t6a", PT1, K1, CT1);
    pt = PT2;
    key = K2;
    in_valid2 = 1'b1;
    check("t6_busy", 128'(busy2), 128'd1);
    tick();
    in_valid2 = 1'b0;
    tick();
    wait_out("t6a", 5, 2);
    tick();
    start("t6b", PT2, K2, CT2);
    wait_out("t6b", 5, 0);
    tick();
    check("t6_out_valid_low", 128'(out_valid2), 128'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
